instruction_fetch: RTL

Fetch stage for the 16-bit CPU. It holds the program counter and requests instruction words from instruction memory over a request/valid handshake. It latches each returned word into an instruction register and presents the decoded fields (`opcode` first) to the downstream ControlUnit. It consumes the ControlUnit's `jump` decision to redirect the PC, and it honours a `stall` from later stages.

---
 rtl/instruction_fetch.sv | 132 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, imem request/valid handshake, instruction register and field decode.
// Optional halt-on-opcode-4'hF support is enabled by defining IFETCH_HALT_EN.
module instruction_fetch #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imemReq,
  output logic [PC_WIDTH-1:0] imemAddr,
  input  logic [15:0]         imemData,
  input  logic                imemValid,
  input  logic                stall,
  input  logic                jump,
  output logic                instrValid,
  output logic [3:0]          opcode,
  output logic [3:0]          rd,
  output logic [3:0]          rs,
  output logic [3:0]          rt,
  output logic [7:0]          imm,
  output logic [PC_WIDTH-1:0] pcOut,
  output logic                halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [15:0]         ir_q, ir_d;
  logic                req_q, req_d;
  logic                valid_q, valid_d;
  logic                halted_q, halted_d;
  logic [15:0]         imm_ext;
  logic [PC_WIDTH-1:0] jump_tgt;
  logic                halt_hit;

  // Immediate zero-extended to 16 bits, then cut to the PC width.
  assign imm_ext  = {8'h00, ir_q[7:0]};
  assign jump_tgt = imm_ext[PC_WIDTH-1:0];

`ifdef IFETCH_HALT_EN
  assign halt_hit = (ir_q[15:12] == 4'hF);
`else
  assign halt_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    ir_d     = ir_q;
    case (state_q)
      // After reset req_q is still low: spend one cycle raising the request.
      S_FETCH: begin
        if (req_q) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WAIT: begin
        if (imemValid) begin
          ir_d     = imemData;
          pc_out_d = pc_q;
          state_d  = S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ISSUE: begin
        if (stall) begin
          state_d = S_ISSUE;
        end else if (halt_hit) begin
          state_d = S_HALT;
        end else if (jump) begin
          pc_d    = jump_tgt;
          state_d = S_FETCH;
        end else begin
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    req_d    = (state_d == S_FETCH);
    valid_d  = (state_d == S_ISSUE);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      ir_q     <= 16'h0000;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      ir_q     <= ir_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign imemReq    = req_q;
  assign imemAddr   = pc_q;
  assign instrValid = valid_q;
  assign opcode     = ir_q[15:12];
  assign rd         = ir_q[11:8];
  assign rs         = ir_q[7:4];
  assign rt         = ir_q[3:0];
  assign imm        = ir_q[7:0];
  assign pcOut      = pc_out_q;
  assign halted     = halted_q;

endmodule
